// File: rtl/octal_ram_cfg_seq.sv
// -----------------------------------------------------------------------------
// octal_ram_cfg_seq
//
// Power-up configuration sequencer for an octal RAM controller. After reset it
// waits POWERUP_WAIT cycles, writes every entry of a mode-register table,
// reads back the entries that carry a nonzero verify mask and compares them.
// A readback mismatch restarts the whole write-and-verify pass up to MAX_RETRY
// times. A missing acknowledge fails the sequence at once, with no retry.
//
// Ports
//   iClk       in   clock, rising edge
//   iRst_N     in   synchronous active-low reset
//   iStart     in   one-cycle start/restart request (honoured in IDLE/DONE/FAIL)
//   oReq       out  mode-register access request
//   oReqWr     out  1 = write, 0 = read
//   oReqAddr   out  mode-register address
//   oReqData   out  write data (0 on reads)
//   iAck       in   one-cycle access-complete pulse
//   iRdData    in   read data, valid with iAck on a read
//   oBusy      out  sequence in progress (includes the power-up wait)
//   oDone      out  all entries written and verified
//   oErr       out  sequence failed
//   oErrCode   out  0 none, 1 readback mismatch, 2 ack timeout
//   oFailIdx   out  table index of the failing entry
//   oRetryCnt  out  retries consumed
// -----------------------------------------------------------------------------
module octal_ram_cfg_seq #(
    parameter int unsigned           NUM_REGS     = 4,
    parameter logic [NUM_REGS*8-1:0] REG_ADDR     = {8'h08, 8'h06, 8'h04, 8'h00},
    parameter logic [NUM_REGS*8-1:0] REG_DATA     = {8'h00, 8'hF0, 8'h40, 8'h28},
    parameter logic [NUM_REGS*8-1:0] REG_VMASK    = {8'hFF, 8'h00, 8'hFF, 8'hFF},
    parameter int unsigned           POWERUP_WAIT = 20000,
    parameter int unsigned           AUTO_START   = 1,
    parameter int unsigned           ACK_TIMEOUT  = 255,
    parameter int unsigned           MAX_RETRY    = 2,
    localparam int unsigned          IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             iClk,
    input  logic             iRst_N,
    input  logic             iStart,
    output logic             oReq,
    output logic             oReqWr,
    output logic [7:0]       oReqAddr,
    output logic [7:0]       oReqData,
    input  logic             iAck,
    input  logic [7:0]       iRdData,
    output logic             oBusy,
    output logic             oDone,
    output logic             oErr,
    output logic [1:0]       oErrCode,
    output logic [IDX_W-1:0] oFailIdx,
    output logic [3:0]       oRetryCnt
);

    typedef enum logic [3:0] {
        StIdle,
        StPwait,
        StWrReq,
        StWrWait,
        StRdReq,
        StRdWait,
        StCheck,
        StDone,
        StFail
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    localparam logic [19:0] PW_LAST  = 20'(POWERUP_WAIT - 1);
    localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);
    localparam logic [3:0]  RETRY_MX = 4'(MAX_RETRY);

    function automatic logic [7:0] f_byte(input logic [NUM_REGS*8-1:0] tbl, input int idx);
        return tbl[idx*8 +: 8];
    endfunction

    state_e           r_state;
    logic [19:0]      r_pw_cnt;
    logic [15:0]      r_to_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_rd_data;
    logic             r_req;
    logic             r_req_wr;
    logic [7:0]       r_req_addr;
    logic [7:0]       r_req_data;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic [IDX_W-1:0] r_fail_idx;
    logic [3:0]       r_retry_cnt;

    logic [7:0]       w_cur_addr;
    logic [7:0]       w_cur_data;
    logic [7:0]       w_cur_mask;
    logic             w_mismatch;
    logic             w_last_wr;
    logic             w_timeout;
    logic             w_first_rd_vld;
    logic [IDX_W-1:0] w_first_rd_idx;
    logic             w_next_rd_vld;
    logic [IDX_W-1:0] w_next_rd_idx;
    logic [7:0]       w_next_rd_addr;

    assign w_cur_addr     = f_byte(REG_ADDR, int'(r_idx));
    assign w_cur_data     = f_byte(REG_DATA, int'(r_idx));
    assign w_cur_mask     = f_byte(REG_VMASK, int'(r_idx));
    assign w_mismatch     = |((r_rd_data ^ w_cur_data) & w_cur_mask);
    assign w_last_wr      = (int'(r_idx) == int'(NUM_REGS) - 1);
    assign w_timeout      = (r_to_cnt == TO_LAST);
    assign w_next_rd_addr = f_byte(REG_ADDR, int'(w_next_rd_idx));

    // Lowest verified entry overall, and lowest verified entry above r_idx.
    // Scanning downwards lets the last hit be the lowest index.
    always_comb begin
        w_first_rd_vld = 1'b0;
        w_first_rd_idx = '0;
        w_next_rd_vld  = 1'b0;
        w_next_rd_idx  = '0;
        for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
            if (f_byte(REG_VMASK, i) != 8'h00) begin
                w_first_rd_vld = 1'b1;
                w_first_rd_idx = IDX_W'(i);
                if (i > int'(r_idx)) begin
                    w_next_rd_vld = 1'b1;
                    w_next_rd_idx = IDX_W'(i);
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_N) begin
            r_state     <= StPwait;
            r_pw_cnt    <= '0;
            r_to_cnt    <= '0;
            r_idx       <= '0;
            r_rd_data   <= '0;
            r_req       <= 1'b0;
            r_req_wr    <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_fail_idx  <= '0;
            r_retry_cnt <= '0;
        end else begin
            case (r_state)
                StPwait: begin
                    if (r_pw_cnt == PW_LAST) begin
                        r_pw_cnt <= '0;
                        r_idx    <= '0;
                        if (AUTO_START != 0) begin
                            r_state <= StWrReq;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_pw_cnt <= r_pw_cnt + 20'd1;
                    end
                end

                // Start issues write 0 directly so oReq rises on the next cycle.
                StIdle, StDone, StFail: begin
                    if (iStart) begin
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_err_code  <= ERR_NONE;
                        r_fail_idx  <= '0;
                        r_retry_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_idx       <= '0;
                        r_req       <= 1'b1;
                        r_req_wr    <= 1'b1;
                        r_req_addr  <= f_byte(REG_ADDR, 0);
                        r_req_data  <= f_byte(REG_DATA, 0);
                        r_to_cnt    <= '0;
                        r_state     <= StWrWait;
                    end
                end

                // Request-gap cycle: oReq is low here, raised at the end of it.
                StWrReq: begin
                    r_req      <= 1'b1;
                    r_req_wr   <= 1'b1;
                    r_req_addr <= w_cur_addr;
                    r_req_data <= w_cur_data;
                    r_to_cnt   <= '0;
                    r_state    <= StWrWait;
                end

                StWrWait: begin
                    if (iAck) begin
                        r_req <= 1'b0;
                        if (!w_last_wr) begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= StWrReq;
                        end else if (w_first_rd_vld) begin
                            r_idx   <= w_first_rd_idx;
                            r_state <= StRdReq;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= StDone;
                        end
                    end else if (w_timeout) begin
                        r_req      <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                        r_fail_idx <= r_idx;
                        r_busy     <= 1'b0;
                        r_state    <= StFail;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end

                StRdReq: begin
                    r_req      <= 1'b1;
                    r_req_wr   <= 1'b0;
                    r_req_addr <= w_cur_addr;
                    r_req_data <= 8'h00;
                    r_to_cnt   <= '0;
                    r_state    <= StRdWait;
                end

                StRdWait: begin
                    if (iAck) begin
                        r_req     <= 1'b0;
                        r_rd_data <= iRdData;
                        r_state   <= StCheck;
                    end else if (w_timeout) begin
                        r_req      <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                        r_fail_idx <= r_idx;
                        r_busy     <= 1'b0;
                        r_state    <= StFail;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end

                // CHECK doubles as the gap cycle before the next read.
                StCheck: begin
                    if (w_mismatch) begin
                        if (r_retry_cnt < RETRY_MX) begin
                            r_retry_cnt <= r_retry_cnt + 4'd1;
                            r_idx       <= '0;
                            r_state     <= StWrReq;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_MISMATCH;
                            r_fail_idx <= r_idx;
                            r_busy     <= 1'b0;
                            r_state    <= StFail;
                        end
                    end else if (w_next_rd_vld) begin
                        r_idx      <= w_next_rd_idx;
                        r_req      <= 1'b1;
                        r_req_wr   <= 1'b0;
                        r_req_addr <= w_next_rd_addr;
                        r_req_data <= 8'h00;
                        r_to_cnt   <= '0;
                        r_state    <= StRdWait;
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StDone;
                    end
                end

                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign oReq      = r_req;
    assign oReqWr    = r_req_wr;
    assign oReqAddr  = r_req_addr;
    assign oReqData  = r_req_data;
    assign oBusy     = r_busy;
    assign oDone     = r_done;
    assign oErr      = r_err;
    assign oErrCode  = r_err_code;
    assign oFailIdx  = r_fail_idx;
    assign oRetryCnt = r_retry_cnt;

endmodule

// File: tb/tb_octal_ram_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_octal_ram_cfg_seq
//
// Directed bench for octal_ram_cfg_seq. Instance A runs with AUTO_START=1,
// POWERUP_WAIT=8, ACK_TIMEOUT=10, MAX_RETRY=2; instance B uses AUTO_START=0.
// Expected requests are queued before each pass and popped as the DUT issues
// them; the bench acts as the controller and returns the queued read data.
// -----------------------------------------------------------------------------
module tb_octal_ram_cfg_seq;

    localparam int unsigned PW  = 8;
    localparam int unsigned TO  = 10;
    localparam int unsigned MR  = 2;
    localparam logic [7:0] W_ADDR [4] = '{8'h00, 8'h04, 8'h06, 8'h08};
    localparam logic [7:0] W_DATA [4] = '{8'h28, 8'h40, 8'hF0, 8'h00};

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] rdata;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic       rst_a = 1'b0, start_a = 1'b0, ack_a = 1'b0;
    logic [7:0] rd_a = 8'h00;
    logic       req_a, req_wr_a, busy_a, done_a, err_a;
    logic [7:0] req_addr_a, req_data_a;
    logic [1:0] err_code_a, fail_idx_a;
    logic [3:0] retry_a;

    // Instance B
    logic       rst_b = 1'b0, start_b = 1'b0, ack_b = 1'b0;
    logic [7:0] rd_b = 8'h00;
    logic       req_b, req_wr_b, busy_b, done_b, err_b;
    logic [7:0] req_addr_b, req_data_b;
    logic [1:0] err_code_b, fail_idx_b;
    logic [3:0] retry_b;

    octal_ram_cfg_seq #(
        .POWERUP_WAIT (PW),
        .AUTO_START   (1),
        .ACK_TIMEOUT  (TO),
        .MAX_RETRY    (MR)
    ) dut_a (
        .iClk      (clk),
        .iRst_N    (rst_a),
        .iStart    (start_a),
        .oReq      (req_a),
        .oReqWr    (req_wr_a),
        .oReqAddr  (req_addr_a),
        .oReqData  (req_data_a),
        .iAck      (ack_a),
        .iRdData   (rd_a),
        .oBusy     (busy_a),
        .oDone     (done_a),
        .oErr      (err_a),
        .oErrCode  (err_code_a),
        .oFailIdx  (fail_idx_a),
        .oRetryCnt (retry_a)
    );

    octal_ram_cfg_seq #(
        .POWERUP_WAIT (PW),
        .AUTO_START   (0),
        .ACK_TIMEOUT  (TO),
        .MAX_RETRY    (MR)
    ) dut_b (
        .iClk      (clk),
        .iRst_N    (rst_b),
        .iStart    (start_b),
        .oReq      (req_b),
        .oReqWr    (req_wr_b),
        .oReqAddr  (req_addr_b),
        .oReqData  (req_data_b),
        .iAck      (ack_b),
        .iRdData   (rd_b),
        .oBusy     (busy_b),
        .oDone     (done_b),
        .oErr      (err_b),
        .oErrCode  (err_code_b),
        .oFailIdx  (fail_idx_b),
        .oRetryCnt (retry_b)
    );

    req_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_writes();
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, W_ADDR[i], W_DATA[i], 8'h00});
    endtask

    task automatic push_rd(input logic [7:0] addr, input logic [7:0] rdata);
        exp_q.push_back('{1'b0, addr, 8'h00, rdata});
    endtask

    // Waits (bounded) at negedges for oReq of instance A.
    task automatic wait_req(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req_a) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_req_seen"}, 32'(ok), 32'd1);
    endtask

    // Acts as the controller for one request: compare against the scoreboard,
    // ack after 'delay' cycles, optionally poke iStart while waiting, and
    // optionally check the one-cycle gap to the following request.
    task automatic serve(input string tag, input int delay, input bit gap_chk, input bit poke);
        bit   ok;
        req_t e;
        wait_req(tag, ok);
        if (!ok) return;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk({tag, "_wr"}, 32'(req_wr_a), 32'(e.wr));
        chk({tag, "_addr"}, 32'(req_addr_a), 32'(e.addr));
        chk({tag, "_data"}, 32'(req_data_a), 32'(e.data));
        if (poke) begin
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            repeat (delay - 1) @(negedge clk);
        end else begin
            repeat (delay) @(negedge clk);
        end
        chk({tag, "_held"}, 32'(req_a), 32'd1);
        chk({tag, "_addr_stable"}, 32'(req_addr_a), 32'(e.addr));
        ack_a = 1'b1;
        rd_a  = e.rdata;
        @(negedge clk);
        ack_a = 1'b0;
        rd_a  = 8'h00;
        chk({tag, "_req_drop"}, 32'(req_a), 32'd0);
        if (gap_chk) begin
            @(negedge clk);
            chk({tag, "_gap1"}, 32'(req_a), 32'd1);
        end
    endtask

    task automatic serve_writes(input string tag, input bit poke1);
        for (int i = 0; i < 4; i++) serve(tag, 3, i < 3, poke1 && (i == 1));
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        bit   ok;
        req_t e;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_a), 32'd1);
        chk("rst_req", 32'(req_a), 32'd0);
        chk("rst_wr", 32'(req_wr_a), 32'd0);
        chk("rst_addr", 32'(req_addr_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_code", 32'(err_code_a), 32'd0);
        chk("rst_fidx", 32'(fail_idx_a), 32'd0);
        chk("rst_retry", 32'(retry_a), 32'd0);
        chk("rst_b_busy", 32'(busy_b), 32'd1);

        // AUTO_START=0: iStart ignored in PWAIT, then idle until iStart
        rst_b = 1'b1;
        @(negedge clk);
        chk("b_pwait_busy", 32'(busy_b), 32'd1);
        repeat (2) @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_pwait_nostart", 32'(req_b), 32'd0);
        repeat (12) @(negedge clk);
        chk("b_idle_busy", 32'(busy_b), 32'd0);
        chk("b_idle_req", 32'(req_b), 32'd0);
        chk("b_idle_done", 32'(done_b), 32'd0);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_start_req", 32'(req_b), 32'd1);
        chk("b_start_wr", 32'(req_wr_b), 32'd1);
        chk("b_start_addr", 32'(req_addr_b), 32'h00);
        chk("b_start_data", 32'(req_data_b), 32'h28);
        chk("b_start_busy", 32'(busy_b), 32'd1);
        rst_b = 1'b0;

        // Normal pass after auto-start
        push_writes();
        push_rd(8'h00, 8'h28);
        push_rd(8'h04, 8'h40);
        push_rd(8'h08, 8'h00);
        rst_a = 1'b1;
        @(negedge clk);
        chk("pw_busy", 32'(busy_a), 32'd1);
        serve_writes("norm_w", 1'b0);
        repeat (3) serve("norm_r", 3, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("norm_done", 32'(done_a), 32'd1);
        chk("norm_busy", 32'(busy_a), 32'd0);
        chk("norm_err", 32'(err_a), 32'd0);
        chk("norm_retry", 32'(retry_a), 32'd0);
        chk("norm_q_empty", 32'(exp_q.size()), 32'd0);

        // Spurious ack with oReq low
        ack_a = 1'b1;
        rd_a  = 8'hAA;
        @(negedge clk);
        ack_a = 1'b0;
        rd_a  = 8'h00;
        @(negedge clk);
        chk("spur_req", 32'(req_a), 32'd0);
        chk("spur_done", 32'(done_a), 32'd1);

        // Single retry; iStart during WR_WAIT of entry 1 must be ignored
        push_writes();
        push_rd(8'h00, 8'h20);
        push_writes();
        push_rd(8'h00, 8'h28);
        push_rd(8'h04, 8'h40);
        push_rd(8'h08, 8'h00);
        pulse_start_a();
        chk("retry_req_next", 32'(req_a), 32'd1);
        chk("retry_done_clr", 32'(done_a), 32'd0);
        serve_writes("retry_w1", 1'b1);
        serve("retry_rbad", 3, 1'b0, 1'b0);
        serve_writes("retry_w2", 1'b0);
        repeat (3) serve("retry_r", 3, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("retry_done", 32'(done_a), 32'd1);
        chk("retry_cnt", 32'(retry_a), 32'd1);
        chk("retry_q_empty", 32'(exp_q.size()), 32'd0);

        // Persistent mismatch on entry 1: three passes then FAIL
        for (int p = 0; p < 3; p++) begin
            push_writes();
            push_rd(8'h00, 8'h28);
            push_rd(8'h04, 8'h47);
        end
        pulse_start_a();
        chk("mm_retry_clr", 32'(retry_a), 32'd0);
        for (int p = 0; p < 3; p++) begin
            serve_writes("mm_w", 1'b0);
            serve("mm_r0", 3, 1'b0, 1'b0);
            serve("mm_r1", 3, 1'b0, 1'b0);
        end
        repeat (2) @(negedge clk);
        chk("mm_err", 32'(err_a), 32'd1);
        chk("mm_code", 32'(err_code_a), 32'd1);
        chk("mm_fidx", 32'(fail_idx_a), 32'd1);
        chk("mm_retry", 32'(retry_a), 32'd2);
        chk("mm_done", 32'(done_a), 32'd0);
        chk("mm_busy", 32'(busy_a), 32'd0);
        chk("mm_q_empty", 32'(exp_q.size()), 32'd0);

        // Ack timeout on write entry 2
        for (int i = 0; i < 2; i++) exp_q.push_back('{1'b1, W_ADDR[i], W_DATA[i], 8'h00});
        pulse_start_a();
        chk("to_err_clr", 32'(err_a), 32'd0);
        serve("to_w0", 3, 1'b1, 1'b0);
        serve("to_w1", 3, 1'b1, 1'b0);
        wait_req("to_w2", ok);
        chk("to_w2_addr", 32'(req_addr_a), 32'h06);
        cnt = 0;
        while (req_a && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_req_cycles", 32'(cnt), 32'(TO));
        chk("to_err", 32'(err_a), 32'd1);
        chk("to_code", 32'(err_code_a), 32'd2);
        chk("to_fidx", 32'(fail_idx_a), 32'd2);
        chk("to_retry", 32'(retry_a), 32'd0);
        chk("to_busy", 32'(busy_a), 32'd0);

        // Reset during RD_WAIT
        push_writes();
        pulse_start_a();
        serve_writes("rr_w", 1'b0);
        wait_req("rr_rd", ok);
        chk("rr_rd_wr", 32'(req_wr_a), 32'd0);
        chk("rr_rd_addr", 32'(req_addr_a), 32'h00);
        rst_a = 1'b0;
        @(negedge clk);
        chk("rr_req_drop", 32'(req_a), 32'd0);
        chk("rr_busy", 32'(busy_a), 32'd1);
        chk("rr_err_clr", 32'(err_a), 32'd0);
        rst_a = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!req_a && cnt < 50);
        // PW counted cycles plus the one request-gap cycle before write 0
        chk("rr_pwait_len", 32'(cnt), 32'(PW + 1));
        exp_q.delete();
        push_writes();
        push_rd(8'h00, 8'h28);
        push_rd(8'h04, 8'h40);
        push_rd(8'h08, 8'h00);
        serve_writes("rr2_w", 1'b0);
        repeat (3) serve("rr2_r", 3, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rr2_done", 32'(done_a), 32'd1);
        chk("rr2_retry", 32'(retry_a), 32'd0);
        e = '0;
        chk("rr2_q_empty", 32'(exp_q.size()), 32'(e.addr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/octal_ram_cfg_seq.md
OCTAL_RAM_CFG_SEQ -- requirements
Module: octal_ram_cfg_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4: number of mode-register table entries, range 1..16.
REQ-002 SHALL have parameter REG_ADDR, default {8'h08,8'h06,8'h04,8'h00}: packed NUM_REGS*8 addresses, entry 0 in bits [7:0].
REQ-003 SHALL have parameter REG_DATA, default {8'h00,8'hF0,8'h40,8'h28}: packed NUM_REGS*8 write data, entry 0 in bits [7:0].
REQ-004 SHALL have parameter REG_VMASK, default {8'hFF,8'h00,8'hFF,8'hFF}: packed per-entry readback compare mask; 8'h00 means the entry is not read back.
REQ-005 SHALL have parameter POWERUP_WAIT, default 20000: cycles to wait after reset before auto-start, range 1..2^20-1.
REQ-006 SHALL have parameter AUTO_START, default 1: 1 means run automatically after the power-up wait.
REQ-007 SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles oReq may stay high without iAck, range 1..65535.
REQ-008 SHALL have parameter MAX_RETRY, default 2: full write-and-verify passes repeated after a mismatch, range 0..15.
REQ-009 SHALL have the following ports:
- iClk  in  1  clock; all logic on the rising edge.
- iRst_N  in  1  synchronous, active-low reset.
- iStart  in  1  single-cycle start or restart request.
- oReq  out  1  mode-register access request to the controller.
- oReqWr  out  1  1 = mode-register write, 0 = mode-register read.
- oReqAddr  out  8  mode-register address.
- oReqData  out  8  write data; 0 on reads.
- iAck  in  1  single-cycle pulse meaning the access is complete.
- iRdData  in  8  read data, valid only while iAck is high on a read.
- oBusy  out  1  sequence in progress, including the power-up wait.
- oDone  out  1  level; all entries written and verified.
- oErr  out  1  level; sequence failed.
- oErrCode  out  2  0 = none, 1 = readback mismatch, 2 = ack timeout.
- oFailIdx  out  IDX_W  index of the failing entry; IDX_W = max(1, ceil(log2(NUM_REGS))).
- oRetryCnt  out  4  number of retries consumed.

Function
REQ-010 SHALL implement the states IDLE, PWAIT, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE, FAIL.
REQ-011 SHALL handle the power-up wait as follows:
- After reset, go to PWAIT.
- Count POWERUP_WAIT cycles, then go to WR_REQ if AUTO_START=1, else to IDLE.
- iStart is ignored during PWAIT.
REQ-012 SHALL, on iStart sampled in IDLE, DONE or FAIL, clear oDone, oErr, oErrCode, oFailIdx and oRetryCnt, and assert oReq on the next cycle (write entry 0).
REQ-013 SHALL ignore iStart in every other state.
REQ-014 SHALL follow this request handshake:
- oReq, oReqWr, oReqAddr and oReqData are registered and stay stable while oReq=1.
- The request completes on the first cycle iAck=1 with oReq=1.
- oReq is 0 in the cycle after that ack.
- iAck while oReq=0 is ignored.
REQ-015 SHALL write all NUM_REGS entries in order 0..NUM_REGS-1 using REG_ADDR/REG_DATA, with oReq low for exactly one cycle between consecutive requests.
REQ-016 SHALL, after the writes, read back only entries with a nonzero mask, in ascending order.
REQ-017 SHALL capture iRdData on the ack and evaluate it in CHECK the following cycle: mismatch when (iRdData ^ REG_DATA[i]) & REG_VMASK[i] != 0.
REQ-018 SHALL handle a mismatch as follows:
- If oRetryCnt < MAX_RETRY: increment oRetryCnt and restart from write entry 0.
- Else: go to FAIL with oErrCode=1 and oFailIdx = that entry.
REQ-019 SHALL, if all masks are zero, go to DONE directly after the last write ack.
REQ-020 SHALL handle the ack timeout as follows:
- A per-request counter clears on each new request.
- If it reaches ACK_TIMEOUT while waiting, deassert oReq next cycle.
- Go to FAIL with oErrCode=2 and oFailIdx = the current entry; no retry.
REQ-021 SHALL give the DONE and FAIL behaviour:
- DONE: oDone=1, oBusy=0.
- FAIL: oErr=1, oBusy=0.
- Both hold until the next iStart or reset.
REQ-022 SHALL assert oBusy in PWAIT, WR_*, RD_* and CHECK.

Reset
REQ-023 SHALL, while iRst_N=0 at a clock edge, set the state to PWAIT with its counter at 0.
REQ-024 SHALL, on reset, set oReq, oReqWr, oReqAddr, oReqData, oDone, oErr, oErrCode, oFailIdx and oRetryCnt to 0, and oBusy to 1.
REQ-025 SHALL let reset mid-transaction drop oReq in the next cycle and abandon the sequence.

Verification
REQ-026 SHALL cover a normal pass (defaults, POWERUP_WAIT=8, ack 3 cycles after each request, reads return the written data):
- Writes go out as (00,28), (04,40), (06,F0), (08,00).
- Reads go out to 00, 04, 08; address 06 is not read.
- oDone=1, oRetryCnt=0.
REQ-027 SHALL cover a single retry (first read of 00 returns 8'h20):
- The full write sequence is repeated.
- The second pass matches; oDone=1, oRetryCnt=1.
REQ-028 SHALL cover a persistent mismatch (read of 04 always returns 8'h47, MAX_RETRY=2):
- Three passes run.
- oErr=1, oErrCode=1, oFailIdx=1, oRetryCnt=2.
REQ-029 SHALL cover a timeout (ACK_TIMEOUT=10, no iAck for write entry 2):
- oReq drops after 10 cycles.
- oErr=1, oErrCode=2, oFailIdx=2.
REQ-030 SHALL cover handshake and reset edge cases:
- iStart during WR_WAIT is ignored.
- A spurious iAck with oReq=0 has no effect.
- iRst_N=0 during RD_WAIT: the next cycle shows oReq=0, oBusy=1, and PWAIT restarts.
REQ-031 SHALL cover AUTO_START=0: after PWAIT the block sits idle with oBusy=0 until iStart, and oReq rises on the cycle after iStart.
